// File: rtl/if_pkg.sv
// Shared types for the IF stage: fetch FSM states, the queued fetch entry and
// PC arithmetic helpers.
package if_pkg;

  typedef enum logic [1:0] {
    RUN,
    STOPPING,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instn;
    logic [31:0] pc;
    logic [31:0] nextpc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; flush wins over push/pop.
// Pointers wrap explicitly so DEPTH need not be a power of two.
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic            valid,
  output logic [CNTW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  // NOTE: storage is not reset; a stale head is never visible because outputs are masked by valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch controller: PC, credit-based imem requests, in-order response queue,
// branch redirect with in-flight discard, halt PC. FETCH_PERF_CNT_EN adds perf counters.
module pc_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_PC  = 32'd36,
  parameter int          QDEPTH   = 2,
  parameter int          CNTW     = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instn,
  output logic [31:0] if_pc,
  output logic [31:0] if_nextpc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  fetch_state_t    state;
  logic [31:0]     pc;
  logic [31:0]     resp_pc;
  logic [CNTW-1:0] outstanding;
  logic [CNTW-1:0] drop;
  logic [CNTW-1:0] occupancy;
  logic [CNTW-1:0] out_nxt;
  logic [CNTW:0]   inflight;
  logic [31:0]     pc_nxt;
  logic [31:0]     target;
  logic            issue;
  logic            rsp;
  logic            rsp_keep;
  logic            pop;
  logic            q_valid;
  fetch_entry_t    q_head;
  fetch_entry_t    q_in;

  assign target   = branch_target & ~32'h3;
  assign inflight = {1'b0, occupancy} + {1'b0, outstanding};
  assign issue    = (state == RUN) && (pc != HALT_PC) &&
                    (inflight < (CNTW+1)'(QDEPTH)) && !branch_taken;
  assign imem_req  = issue && !reset;
  assign imem_addr = pc;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp      = imem_rvalid && (outstanding != '0);
  assign rsp_keep = rsp && (drop == '0) && !branch_taken;
  assign pop      = q_valid && if_ready && !branch_taken;

  assign q_in = '{instn: imem_rdata, pc: resp_pc, nextpc: resp_pc + PC_STEP};

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    out_nxt = outstanding;
    if (issue) out_nxt = out_nxt + CNTW'(1);
    if (rsp)   out_nxt = out_nxt - CNTW'(1);
    pc_nxt = issue ? pc + PC_STEP : pc;
  end

  fetch_queue #(.DEPTH(QDEPTH), .CNTW(CNTW)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (branch_taken),
    .push      (rsp_keep),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (occupancy)
  );

  // resp_pc tags the next kept response; drops never advance it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      if (branch_taken) begin
        pc      <= target;
        resp_pc <= target;
        drop    <= out_nxt;
      end else begin
        pc <= pc_nxt;
        if (rsp_keep) resp_pc <= resp_pc + PC_STEP;
        if (rsp && (drop != '0)) drop <= drop - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (branch_taken) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN:      if (pc_nxt == HALT_PC) state <= STOPPING;
        STOPPING: if ((occupancy == '0) && (outstanding == '0)) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default:  state <= HALT;
      endcase
    end
  end

  assign if_valid  = q_valid;
  assign if_instn  = q_valid ? q_head.instn  : '0;
  assign if_pc     = q_valid ? q_head.pc     : '0;
  assign if_nextpc = q_valid ? q_head.nextpc : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [CNTW:0] flush_inc;

  // Redirects discard the whole queue plus any same-cycle response; later drops count one each.
  always_comb begin
    flush_inc = '0;
    if (branch_taken)             flush_inc = {1'b0, occupancy} + {{CNTW{1'b0}}, rsp};
    else if (rsp && (drop != '0)) flush_inc = (CNTW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= sat_add32(perf_fetched, 32'd1);
      perf_flushed <= sat_add32(perf_flushed, 32'(flush_inc));
    end
  end
`endif

  assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: cycle-by-cycle vector table plus a stall/drain sequence,
// against a 1- or 2-cycle latency instruction memory model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instn;
  logic [31:0] if_pc;
  logic [31:0] if_nextpc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int failures = 0;
  int lat = 1;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instn      (if_instn),
    .if_pc         (if_pc),
    .if_nextpc     (if_nextpc),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed)
`endif
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    return 32'h1357_0000 ^ (a << 4) ^ a;
  endfunction

  // Instruction memory: in-order, fixed latency of 1 or 2 cycles, reset with the DUT.
  logic        s1_v, s2_v;
  logic [31:0] s1_a, s2_a;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0;
    end else begin
      s1_v <= imem_req; s1_a <= imem_addr;
      s2_v <= s1_v;     s2_a <= s1_a;
    end
  end
  assign imem_rvalid = (lat == 1) ? s1_v : s2_v;
  assign imem_rdata  = img((lat == 1) ? s1_a : s2_a);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    int          lat;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input int l, input logic rdy, input logic br,
                              input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic hlt);
    vec_t v;
    v.rst = rst; v.lat = l; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.hlt = hlt;
    return v;
  endfunction

  initial begin
    int n_req;
    int n_pop;
    logic [31:0] exp_pc;

    // Straight run at latency 1 into HALT_PC=36, then redirect to 0.
    vecs.push_back(mk(1, 1, 1, 0, 0,      0, 32'd0,  0, 0,      0));
    vecs.push_back(mk(1, 1, 1, 0, 0,      0, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd4,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd8,  1, 32'd0,  0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd8,  1, 32'd4,  0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd12, 0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd16, 1, 32'd8,  0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd16, 1, 32'd12, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd20, 0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd24, 1, 32'd16, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd24, 1, 32'd20, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd28, 0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd32, 1, 32'd24, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd32, 1, 32'd28, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd36, 0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd36, 1, 32'd32, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd36, 0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'd36, 0, 0,      1));
    vecs.push_back(mk(0, 1, 1, 1, 32'd0,  0, 32'd36, 0, 0,      1));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd0,  0, 0,      0));
    // Redirect coinciding with a pop and a push: pushed word 4 must vanish.
    vecs.push_back(mk(1, 1, 1, 0, 0,      0, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd4,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h100,0, 32'd8,  1, 32'd0,  0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'h100,0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'h104,0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      0, 32'h108,1, 32'h100,0));
    // Latency 2, redirect to 0x47 with two in flight, then reset with two outstanding.
    vecs.push_back(mk(1, 2, 1, 0, 0,      0, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      1, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      1, 32'd4,  0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 1, 32'h47, 0, 32'd8,  0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      1, 32'h44, 0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      1, 32'h48, 0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      0, 32'h4C, 0, 0,      0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      0, 32'h4C, 1, 32'h44, 0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      1, 32'h4C, 1, 32'h48, 0));
    vecs.push_back(mk(0, 2, 1, 0, 0,      1, 32'h50, 0, 0,      0));
    vecs.push_back(mk(1, 1, 1, 0, 0,      0, 32'd0,  0, 0,      0));
    vecs.push_back(mk(0, 1, 1, 0, 0,      1, 32'd0,  0, 0,      0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset = vecs[i].rst;
      if (vecs[i].rst) lat = vecs[i].lat;
      if_ready      = vecs[i].rdy;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(negedge clk);
      check($sformatf("v%0d imem_req", i),  32'(imem_req), 32'(vecs[i].req));
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d if_valid", i),  32'(if_valid), 32'(vecs[i].vld));
      check($sformatf("v%0d if_pc", i),     if_pc, vecs[i].pc);
      check($sformatf("v%0d if_instn", i),  if_instn, vecs[i].vld ? img(vecs[i].pc) : 32'd0);
      check($sformatf("v%0d if_nextpc", i), if_nextpc, vecs[i].vld ? vecs[i].pc + 32'd4 : 32'd0);
      check($sformatf("v%0d halted", i),    32'(halted), 32'(vecs[i].hlt));
`ifdef FETCH_PERF_CNT_EN
      if (vecs[i].rst) begin
        check($sformatf("v%0d perf_fetched", i), perf_fetched, 32'd0);
        check($sformatf("v%0d perf_flushed", i), perf_flushed, 32'd0);
      end
`endif
    end

    // Decode stalled for 5 cycles: exactly QDEPTH requests, then a clean in-order drain to halt.
    branch_taken = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; lat = 1; if_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_req = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (imem_req) n_req++;
      @(posedge clk); #1;
    end
    check("stall req count", 32'(n_req), 32'd2);
    @(negedge clk);
    check("stall req low", 32'(imem_req), 32'd0);
    check("stall head pc", if_pc, 32'd0);
    @(posedge clk); #1;
    if_ready = 1'b1;
    n_pop = 0;
    exp_pc = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if_valid) begin
        check($sformatf("drain pop%0d pc", n_pop), if_pc, exp_pc);
        check($sformatf("drain pop%0d instn", n_pop), if_instn, img(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
      if (halted) break;
      @(posedge clk); #1;
    end
    check("drain halted", 32'(halted), 32'd1);
    check("drain pop count", 32'(n_pop), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
